ntt_result_collector: RTL
=========================

# ntt_result_collector

Downstream drain stage for the `NTT1024` core. After the core raises `done`, the block captures the time-framed `dout0` burst stream and de-interleaves it back into natural coefficient order. Even words go to the low half of the ring and odd words to the high half. Each coefficient gets a final conditional subtraction of `q`, and the result is written to the result RAM one word per cycle.

## Interface
- `PE_DEPTH`, default 3: log2 of the core's PE count; burst length B = 2^(PE_DEPTH+1) words.
- `DATA_W`, default 16: coefficient width.
- `ADDR_W`, default 10: result RAM address width (ring ≤ 1024).

Ports:
- `clk`  in  1  system clock, all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `done`  in  1  core completion flag; level or pulse.
- `dout0`  in  32  core output word; bits [DATA_W-1:0] are used, the rest are ignored.
- `q`  in  DATA_W  modulus; must be static while busy.
- `ring_size`  in  12  ring length; power of two; sampled at start.
- `wr_en`  out  1  result RAM write strobe.
- `wr_addr`  out  ADDR_W  natural-order coefficient index.
- `wr_data`  out  DATA_W  reduced coefficient.
- `busy`  out  1  high from start until `finished`.
- `finished`  out  1  one-cycle pulse at end of drain.
- `frame_err`  out  1  sticky framing error; present only with `NTT_COLLECT_FRAME_CHECK_EN`.

## Operation
- The FSM has five states: IDLE, SKIP, BURST, GAP and FINISH.
- **IDLE**
  - A rising edge of `done` (registered `done` & ~previous) starts a drain.
  - On start, latch `ring_size`, set NB = ring_size >> (PE_DEPTH+1) and half = ring_size >> 1.
  - Clear the word index m and the burst counter, then go to SKIP.
  - If NB = 0, go directly to FINISH with no writes.
- **SKIP**
  - Lasts exactly one cycle; `dout0` is ignored.
  - Next state is BURST.
- **BURST**
  - Lasts exactly B cycles; every cycle captures `dout0`, including zero values.
  - Capture address: if m even, addr = m >> 1; if m odd, addr = (m >> 1) + half.
  - Reduction: c = dout0[DATA_W-1:0]; data = (c ≥ q) ? c − q : c.
  - Input is guaranteed < 2q, so no further reduction is applied.
  - m increments every captured word.
  - After the B-th word, go to GAP.
- **GAP**
  - Lasts exactly one cycle; `dout0` is not captured.
  - Increment the burst counter.
  - If bursts done = NB, go to FINISH; otherwise go to BURST.
- **FINISH**
  - Pulse `finished` for one cycle, then go to IDLE.
- `done` activity while not in IDLE is ignored. A `done` still held high on return to IDLE does not retrigger; a new rising edge is required.
- Total writes per drain = ring_size, each address written exactly once.

## Timing
- Reset (asynchronous, active-low): FSM returns to IDLE. All outputs go to 0: `wr_en`, `wr_addr`, `wr_data`, `busy`, `finished`, `frame_err`. Counters clear.
- Reset asserted mid-drain aborts immediately; the partial RAM contents are undefined and no `finished` is issued.
- Start timing: `done` sampled high at edge t0 (rising) → SKIP during cycle t0+1 → first captured word at edge t0+2.
- Write latency: the word captured at edge t appears as `wr_en`/`wr_addr`/`wr_data` registered in the cycle after edge t (one-cycle pipeline).
- `wr_en` is low in the cycle following each GAP cycle.
- `busy` rises at the cycle after t0 and falls together with the `finished` pulse.
- `finished` is asserted in the cycle after the last `wr_en`.
- Drain duration = 2 + NB·(B+1) cycles from t0.

## Configuration
- `NTT_COLLECT_FRAME_CHECK_EN` defined:
  - In GAP, if `dout0` ≠ 0, set `frame_err`.
  - In the first BURST cycle of each burst, if `dout0` = 0, also set `frame_err`.
  - `frame_err` is sticky until reset or the next start.
  - Capture and write behaviour are unchanged.
- Not defined: no check logic and no `frame_err` port.

## Test plan
- q=7681, ring_size=256, PE_DEPTH=3 (B=16, NB=16), stream word k = k+1 → 256 writes. Word0 value 1 → addr 0; word1 value 2 → addr 128; word2 value 3 → addr 1; word255 value 256 → addr 255. `finished` pulses exactly 2+16·17=274 cycles after t0.
- Reduction, same config: inputs 7680, 7681, 15361 → `wr_data` 7680, 0, 7680.
- Zero word at burst position 5 → captured, `wr_data`=0 at its address. Frame check disabled → no error.
- `done` held high for the whole drain plus 10 cycles → exactly one drain, no retrigger. A second `done` pulse during BURST → ignored.
- `reset` low during burst 7 → all outputs 0 next cycle. A subsequent `done` edge → full clean drain of 256 writes.
- With `NTT_COLLECT_FRAME_CHECK_EN`, GAP word 0x5 after burst 3 → `frame_err`=1 from the next cycle and held through `finished`. All 256 writes are still correct.

Source files
------------

// File: rtl/ntt_result_collector.sv
// rtl/ntt_result_collector.sv - NTT1024 drain: de-interleave dout0 bursts, reduce mod q, write result RAM
// Optional framing check enabled by defining NTT_COLLECT_FRAME_CHECK_EN (adds sticky frame_err output).
module ntt_result_collector #(
  parameter int PE_DEPTH = 3,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  input  logic [31:0]       dout0,
  input  logic [DATA_W-1:0] q,
  input  logic [11:0]       ring_size,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              finished
`ifdef NTT_COLLECT_FRAME_CHECK_EN
  ,
  output logic              frame_err
`endif
);
  localparam int BW = PE_DEPTH + 1;

  typedef enum logic [2:0] {IDLE, SKIP, BURST, GAP, FINISH} state_t;
  state_t state, state_nxt;

  logic              done_d;
  logic              start;
  logic [11:0]       nb_start;
  logic [11:0]       nb;
  logic [11:0]       burst_cnt;
  logic [ADDR_W-1:0] half;
  logic [ADDR_W-1:0] m;
  logic [ADDR_W-1:0] cap_addr;
  logic [BW-1:0]     beat;
  logic [DATA_W-1:0] c;
  logic [DATA_W-1:0] c_red;
  logic              last_beat;
  logic              last_burst;
  logic              unused_dout;

  assign start      = done & ~done_d;
  assign nb_start   = ring_size >> BW;
  assign last_beat  = &beat;
  assign last_burst = (burst_cnt + 12'd1) == nb;
  assign c          = dout0[DATA_W-1:0];
  assign c_red      = (c >= q) ? c - q : c;
  // Even stream words fill the low half of the ring, odd words the high half.
  assign cap_addr   = m[0] ? (m >> 1) + half : (m >> 1);
  assign busy       = (state != IDLE);
  assign finished   = (state == FINISH);
  assign unused_dout = ^dout0[31:DATA_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (nb_start == 12'd0) ? FINISH : SKIP;
      SKIP:    state_nxt = BURST;
      BURST:   if (last_beat) state_nxt = GAP;
      GAP:     state_nxt = last_burst ? FINISH : BURST;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_d    <= 1'b0;
      nb        <= '0;
      half      <= '0;
      m         <= '0;
      beat      <= '0;
      burst_cnt <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      done_d <= done;
      wr_en  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          nb        <= nb_start;
          half      <= ring_size[ADDR_W:1];
          m         <= '0;
          beat      <= '0;
          burst_cnt <= '0;
        end
        BURST: begin
          wr_en   <= 1'b1;
          wr_addr <= cap_addr;
          wr_data <= c_red;
          m       <= m + ADDR_W'(1);
          beat    <= beat + BW'(1);
        end
        GAP:     burst_cnt <= burst_cnt + 12'd1;
        default: ;
      endcase
    end
  end

`ifdef NTT_COLLECT_FRAME_CHECK_EN
  // Gap words must be zero and a burst must not open with a zero word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      frame_err <= 1'b0;
    else if (state == IDLE && start)
      frame_err <= 1'b0;
    else if ((state == GAP && c != '0) || (state == BURST && beat == '0 && c == '0))
      frame_err <= 1'b1;
  end
`endif

endmodule
